// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PFX    = 8'hE0;
    localparam logic [7:0] PS2_BRK_PFX    = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // Odd parity over the data byte plus the received parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions a raw asynchronous PS/2 line: 2-FF synchronizer, level debounce,
// and a one-cycle pulse on each filtered high-to-low transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             fall_reg;
    logic [CW-1:0]    cnt_reg;

    // Two-stage synchronizer; the line idles high so reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce: the filtered level follows only after FILTER_LEN differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            fall_reg  <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    fall_reg  <= ~sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign fall = fall_reg;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames 11-bit device-to-host words, checks them,
// and decodes E0/F0 prefixes into key events plus a held make code.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] IDLE_SCAN      = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err
);

    localparam int TW        = $clog2(TIMEOUT_CYCLES);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;

    logic          sample_en;
    logic          data_sync1_reg;
    logic          data_sync2_reg;

    ps2_state_t    state_reg;
    ps2_state_t    state_next;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shreg_reg;
    logic          par_reg;
    logic          brk_reg;
    logic          ext_reg;
    logic [TW-1:0] tmo_cnt_reg;

    logic [7:0]    scan_reg;
    logic [7:0]    code_reg;
    logic          code_valid_reg;
    logic          is_break_reg;
    logic          is_ext_reg;
    logic          frame_err_reg;

    logic          tmo_hit;
    logic          stop_seen;
    logic          frame_ok;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk),
        .fall  (sample_en)
    );

    // Data only needs synchronizing; it is sampled well inside the clock low phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync1_reg <= 1'b1;
            data_sync2_reg <= 1'b1;
        end else begin
            data_sync1_reg <= ps2_data;
            data_sync2_reg <= data_sync1_reg;
        end
    end

    // Stop bit must be high and parity odd for the byte to be accepted.
    assign frame_ok = data_sync2_reg & ps2_parity_ok(shreg_reg, par_reg);

    // Next-state logic; a sample edge on the terminal count beats the timeout.
    always_comb begin
        state_next = state_reg;
        tmo_hit    = 1'b0;
        stop_seen  = 1'b0;
        if (state_reg != IDLE && !sample_en && tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            tmo_hit    = 1'b1;
        end else if (sample_en) begin
            case (state_reg)
                IDLE:    if (!data_sync2_reg) state_next = DATA;
                DATA:    if (bit_cnt_reg == 3'(DATA_BITS - 1)) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    stop_seen  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame watchdog: runs only mid-frame, restarts on every sample edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == IDLE || sample_en || tmo_hit) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
    end

    // Bit capture: LSB-first shift, then the parity bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            par_reg     <= 1'b0;
        end else if (sample_en) begin
            case (state_reg)
                IDLE: bit_cnt_reg <= '0;
                DATA: begin
                    shreg_reg   <= {data_sync2_reg, shreg_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                PARITY:  par_reg <= data_sync2_reg;
                default: ;
            endcase
        end
    end

    // Byte decode: prefix flags, key events, held make code and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            brk_reg        <= 1'b0;
            ext_reg        <= 1'b0;
            scan_reg       <= IDLE_SCAN;
            code_reg       <= '0;
            code_valid_reg <= 1'b0;
            is_break_reg   <= 1'b0;
            is_ext_reg     <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            code_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (tmo_hit) begin
                frame_err_reg <= 1'b1;
                brk_reg       <= 1'b0;
                ext_reg       <= 1'b0;
            end else if (stop_seen) begin
                if (!frame_ok) begin
                    frame_err_reg <= 1'b1;
                end else if (shreg_reg == PS2_EXT_PFX) begin
                    ext_reg <= 1'b1;
                end else if (shreg_reg == PS2_BRK_PFX) begin
                    brk_reg <= 1'b1;
                end else begin
                    code_reg       <= shreg_reg;
                    is_break_reg   <= brk_reg;
                    is_ext_reg     <= ext_reg;
                    code_valid_reg <= 1'b1;
                    brk_reg        <= 1'b0;
                    ext_reg        <= 1'b0;
                    if (!brk_reg) scan_reg <= shreg_reg;
                end
            end
        end
    end

    assign scan       = scan_reg;
    assign code       = code_reg;
    assign code_valid = code_valid_reg;
    assign is_break   = is_break_reg;
    assign is_ext     = is_ext_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 frames with a frame-level event model
// checked every cycle, plus literal expectations at key points.
module tb_ps2_scancode_rx;

    localparam int HALF = 20;     // clk cycles per PS/2 clock half period
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;

    ps2_scancode_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO),
        .IDLE_SCAN      (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan       (scan),
        .code       (code),
        .code_valid (code_valid),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;

    ev_t        exp_q[$];
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;
    logic [7:0] live_scan = 8'h00;
    logic [7:0] live_code = 8'h00;
    bit         live_brk = 1'b0;
    bit         live_ext = 1'b0;
    int         last_ev_cyc = 0;
    int         last_err_cyc = 0;
    int         last_fall_cyc = 0;
    int         stop_fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level model: what a received byte must do to the event stream.
    task automatic model_frame(input logic [7:0] b, input bit good);
        ev_t e;
        e.err = 1'b0; e.code = b; e.brk = m_brk; e.ext = m_ext;
        if (!good) begin
            e.err = 1'b1;
            exp_q.push_back(e);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back(e);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic drive_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ flip_par;
        f[10]  = ~bad_stop;
        return f;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        model_frame(b, !flip_par && !bad_stop);
        drive_bits(make_frame(b, flip_par, bad_stop), 11);
        stop_fall_cyc = last_fall_cyc;
        ps2_data = 1'b1;
        wait_clks(2 * HALF);
        check($sformatf("drained_%02h", b), exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_scan"}, scan, 8'h00);
        check({tag, "_code"}, code, 8'h00);
        check({tag, "_valid"}, code_valid, 0);
        check({tag, "_brk"}, is_break, 0);
        check({tag, "_ext"}, is_ext, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    // Every cycle: pulses must match the model queue in order, held outputs must
    // match the last event seen.
    always @(negedge clk) begin : compare
        ev_t e;
        if (!reset) begin
            check("pulse_exclusive", code_valid & frame_err, 0);
            if (code_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {code_valid, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", frame_err, e.err);
                    if (!e.err) begin
                        check("ev_code", code, e.code);
                        check("ev_brk", is_break, e.brk);
                        check("ev_ext", is_ext, e.ext);
                        live_code = e.code;
                        live_brk  = e.brk;
                        live_ext  = e.ext;
                        if (!e.brk) live_scan = e.code;
                        last_ev_cyc = cyc;
                    end else begin
                        last_err_cyc = cyc;
                    end
                end
            end
            check("scan_hold", scan, live_scan);
            check("code_hold", code, live_code);
            check("brk_hold", is_break, live_brk);
            check("ext_hold", is_ext, live_ext);
        end
    end

    initial begin : stim
        reset = 1'b1;
        wait_clks(5);
        check_reset_values("rst0");
        reset = 1'b0;
        wait_clks(10);

        // 1: plain make code, plus latency from the stop-bit edge
        send_frame(8'h16, 0, 0);
        check("t1_scan", scan, 8'h16);
        check("t1_code", code, 8'h16);
        check_range("t1_latency", last_ev_cyc - stop_fall_cyc, 8, 14);

        // 2: break then a new make
        send_frame(8'hF0, 0, 0);
        send_frame(8'h16, 0, 0);
        check("t2_brk", is_break, 1);
        check("t2_scan_held", scan, 8'h16);
        send_frame(8'h1E, 0, 0);
        check("t2_scan_1e", scan, 8'h1E);

        // 3: extended make, then extended break
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("t3_ext", is_ext, 1);
        check("t3_scan", scan, 8'h75);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("t3_ext_brk", {is_ext, is_break}, 2'b11);
        check("t3_scan_held", scan, 8'h75);

        // 4: parity error, stop error, then a good frame
        send_frame(8'h26, 1, 0);
        send_frame(8'h26, 0, 1);
        check("t4_scan_held", scan, 8'h75);
        send_frame(8'h26, 0, 0);
        check("t4_scan", scan, 8'h26);

        // 5: frame abandoned after four data bits
        model_frame(8'h5A, 0);
        m_brk = 1'b0;
        m_ext = 1'b0;
        drive_bits(make_frame(8'h5A, 0, 0), 5);
        ps2_data = 1'b1;
        wait_clks(TMO + 60);
        check("t5_drained", exp_q.size(), 0);
        check_range("t5_timeout_latency", last_err_cyc - last_fall_cyc, TMO, TMO + 30);
        send_frame(8'h45, 0, 0);
        check("t5_scan", scan, 8'h45);

        // 6a: short low glitch on the clock line while idle
        ps2_clk = 1'b0;
        wait_clks(5);
        ps2_clk = 1'b1;
        wait_clks(4 * HALF);
        check("t6_glitch_drained", exp_q.size(), 0);

        // 6b: reset during bit 5, with a pending break prefix that reset must clear
        send_frame(8'hF0, 0, 0);
        drive_bits(make_frame(8'h33, 0, 0), 6);
        ps2_data = 1'b1;
        wait_clks(5);
        reset = 1'b1;
        exp_q.delete();
        m_brk = 1'b0;
        m_ext = 1'b0;
        live_scan = 8'h00;
        live_code = 8'h00;
        live_brk  = 1'b0;
        live_ext  = 1'b0;
        wait_clks(3);
        check_reset_values("rst1");
        reset = 1'b0;
        wait_clks(HALF);
        send_frame(8'h16, 0, 0);
        check("t6_scan", scan, 8'h16);
        check("t6_brk_cleared", is_break, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time limit so the bench always ends on its own.
    initial begin : watchdog
        #5ms;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
